branch_predictor: RTL and testbench

- Fetch-side counterpart of the execute-stage branch resolver.
- Predicts each fetch's next PC from a direct-mapped branch target buffer (BTB) with 2-bit saturating direction counters.
- Accepts the resolved outcome of every executed instruction, flags mispredictions with the corrected PC, and trains its tables.
- Sits between the PC register/fetch stage and the execute-stage branch resolution outputs.

---
 rtl/branch_predictor.sv | 98 +++++++++
 tb/tb_branch_predictor.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Fetch-side branch predictor.
// A direct-mapped BTB holds a 2-bit direction counter per entry and is trained from resolved execute-stage outcomes.
module branch_predictor #(
  parameter int ENTRY_NUM = 16
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic [31:0] fetchPc,
  output logic        predictTaken,
  output logic [31:0] predictedPc,
  input  logic        exValid,
  input  logic [31:0] exPc,
  input  logic        exIsBranch,
  input  logic        exIsBranchTaken,
  input  logic [31:0] exIrregPc,
  input  logic [31:0] exPredictedPc,
  output logic        mispredict,
  output logic [31:0] redirectPc,
  output logic [31:0] branchCount,
  output logic [31:0] mispredictCount
);
  localparam int IDX   = $clog2(ENTRY_NUM);
  localparam int TAG_W = 30 - IDX;

  logic [ENTRY_NUM-1:0]             r_valid;
  logic [ENTRY_NUM-1:0][TAG_W-1:0]  r_tag;
  logic [ENTRY_NUM-1:0][31:0]       r_target;
  logic [ENTRY_NUM-1:0][1:0]        r_ctr;
  logic [31:0]                      r_branchCount;
  logic [31:0]                      r_mispredictCount;

  logic [IDX-1:0]   w_fIdx, w_eIdx;
  logic [TAG_W-1:0] w_fTag, w_eTag;
  logic             w_fHit, w_eHit;
  logic [31:0]      w_actualNext;
  logic             w_mispredict;
  logic [1:0]       w_eCtr;

  assign w_fIdx = fetchPc[IDX+1:2];
  assign w_fTag = fetchPc[31:IDX+2];
  assign w_eIdx = exPc[IDX+1:2];
  assign w_eTag = exPc[31:IDX+2];
  assign w_fHit = r_valid[w_fIdx] && (r_tag[w_fIdx] == w_fTag);
  assign w_eHit = r_valid[w_eIdx] && (r_tag[w_eIdx] == w_eTag);
  assign w_eCtr = r_ctr[w_eIdx];

  // Lookup always sees the pre-edge table, so a same-cycle update is invisible here.
  assign predictTaken = w_fHit && r_ctr[w_fIdx][1];
  assign predictedPc  = predictTaken ? r_target[w_fIdx] : fetchPc + 32'd4;

  // A non-branch has no irregular target; its successor is simply exPc+4.
  assign w_actualNext = exIsBranch ? exIrregPc : exPc + 32'd4;
  assign w_mispredict = exValid && (w_actualNext != exPredictedPc);
  assign mispredict   = w_mispredict;
  assign redirectPc   = exValid ? w_actualNext : 32'd0;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_valid  <= '0;
      r_tag    <= '0;
      r_target <= '0;
      r_ctr    <= {ENTRY_NUM{2'b01}};
    end else if (exValid) begin
      if (exIsBranch) begin
        if (w_eHit) begin
          if (exIsBranchTaken) begin
            if (w_eCtr != 2'b11) r_ctr[w_eIdx] <= w_eCtr + 2'd1;
            r_target[w_eIdx] <= exIrregPc;
          end else if (w_eCtr != 2'b00) begin
            r_ctr[w_eIdx] <= w_eCtr - 2'd1;
          end
        end else if (exIsBranchTaken) begin
          r_valid[w_eIdx]  <= 1'b1;
          r_tag[w_eIdx]    <= w_eTag;
          r_target[w_eIdx] <= exIrregPc;
          r_ctr[w_eIdx]    <= 2'b10;
        end
      end else if (w_eHit) begin
        r_valid[w_eIdx] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_branchCount     <= '0;
      r_mispredictCount <= '0;
    end else begin
      if (exValid && exIsBranch && (r_branchCount != 32'hFFFF_FFFF))
        r_branchCount <= r_branchCount + 32'd1;
      if (w_mispredict && (r_mispredictCount != 32'hFFFF_FFFF))
        r_mispredictCount <= r_mispredictCount + 32'd1;
    end
  end

  assign branchCount     = r_branchCount;
  assign mispredictCount = r_mispredictCount;
endmodule

// File: tb/tb_branch_predictor.sv
// Directed vector bench for branch_predictor.
// Each row drives one cycle; outputs are compared just before the training edge.
module tb_branch_predictor;
  logic        clk;
  logic        rstN;
  logic [31:0] fetchPc;
  logic        predictTaken;
  logic [31:0] predictedPc;
  logic        exValid;
  logic [31:0] exPc;
  logic        exIsBranch;
  logic        exIsBranchTaken;
  logic [31:0] exIrregPc;
  logic [31:0] exPredictedPc;
  logic        mispredict;
  logic [31:0] redirectPc;
  logic [31:0] branchCount;
  logic [31:0] mispredictCount;

  int checks = 0;
  int errors = 0;

  branch_predictor #(.ENTRY_NUM(16)) dut (
    .clk(clk), .rstN(rstN), .fetchPc(fetchPc),
    .predictTaken(predictTaken), .predictedPc(predictedPc),
    .exValid(exValid), .exPc(exPc), .exIsBranch(exIsBranch),
    .exIsBranchTaken(exIsBranchTaken), .exIrregPc(exIrregPc),
    .exPredictedPc(exPredictedPc), .mispredict(mispredict),
    .redirectPc(redirectPc), .branchCount(branchCount),
    .mispredictCount(mispredictCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] fpc;
    logic        v;
    logic [31:0] pc;
    logic        br;
    logic        tk;
    logic [31:0] irr;
    logic [31:0] ppc;
    logic        e_pt;
    logic [31:0] e_pp;
    logic        e_mp;
    logic [31:0] e_rd;
    logic [31:0] e_bc;
    logic [31:0] e_mc;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    fetchPc = t.fpc; exValid = t.v; exPc = t.pc; exIsBranch = t.br;
    exIsBranchTaken = t.tk; exIrregPc = t.irr; exPredictedPc = t.ppc;
  endtask

  task automatic check_row(input vec_t t, input int row);
    chk("predictTaken", row, {31'd0, predictTaken}, {31'd0, t.e_pt});
    chk("predictedPc", row, predictedPc, t.e_pp);
    chk("mispredict", row, {31'd0, mispredict}, {31'd0, t.e_mp});
    chk("redirectPc", row, redirectPc, t.e_rd);
    chk("branchCount", row, branchCount, t.e_bc);
    chk("mispredictCount", row, mispredictCount, t.e_mc);
  endtask

  initial begin
    //           fetch        v     exPc         br    tk    irr          exPred        pt    predPc       mp    redir        bc     mc
    vecs[0]  = '{32'h100,     1'b0, 32'h0,       1'b0, 1'b0, 32'h0,       32'h0,        1'b0, 32'h104,     1'b0, 32'h0,       32'd0, 32'd0};
    vecs[1]  = '{32'h100,     1'b1, 32'h100,     1'b0, 1'b0, 32'h0,       32'h104,      1'b0, 32'h104,     1'b0, 32'h104,     32'd0, 32'd0};
    vecs[2]  = '{32'h200,     1'b1, 32'h200,     1'b1, 1'b1, 32'h80,      32'h204,      1'b0, 32'h204,     1'b1, 32'h80,      32'd0, 32'd0};
    vecs[3]  = '{32'h200,     1'b0, 32'h0,       1'b0, 1'b0, 32'h0,       32'h0,        1'b1, 32'h80,      1'b0, 32'h0,       32'd1, 32'd1};
    vecs[4]  = '{32'h200,     1'b1, 32'h200,     1'b1, 1'b0, 32'h204,     32'h80,       1'b1, 32'h80,      1'b1, 32'h204,     32'd1, 32'd1};
    vecs[5]  = '{32'h200,     1'b1, 32'h200,     1'b1, 1'b1, 32'h80,      32'h204,      1'b0, 32'h204,     1'b1, 32'h80,      32'd2, 32'd2};
    vecs[6]  = '{32'h200,     1'b1, 32'h200,     1'b1, 1'b1, 32'h80,      32'h80,       1'b1, 32'h80,      1'b0, 32'h80,      32'd3, 32'd3};
    vecs[7]  = '{32'h200,     1'b1, 32'h200,     1'b1, 1'b0, 32'h204,     32'h80,       1'b1, 32'h80,      1'b1, 32'h204,     32'd4, 32'd3};
    vecs[8]  = '{32'h200,     1'b0, 32'h0,       1'b0, 1'b0, 32'h0,       32'h0,        1'b1, 32'h80,      1'b0, 32'h0,       32'd5, 32'd4};
    vecs[9]  = '{32'h600,     1'b1, 32'h600,     1'b1, 1'b1, 32'h40,      32'h604,      1'b0, 32'h604,     1'b1, 32'h40,      32'd5, 32'd4};
    vecs[10] = '{32'h200,     1'b0, 32'h0,       1'b0, 1'b0, 32'h0,       32'h0,        1'b0, 32'h204,     1'b0, 32'h0,       32'd6, 32'd5};
    vecs[11] = '{32'h600,     1'b0, 32'h0,       1'b0, 1'b0, 32'h0,       32'h0,        1'b1, 32'h40,      1'b0, 32'h0,       32'd6, 32'd5};
    vecs[12] = '{32'h600,     1'b1, 32'h600,     1'b0, 1'b0, 32'h0,       32'h40,       1'b1, 32'h40,      1'b1, 32'h604,     32'd6, 32'd5};
    vecs[13] = '{32'h600,     1'b0, 32'h0,       1'b0, 1'b0, 32'h0,       32'h0,        1'b0, 32'h604,     1'b0, 32'h0,       32'd6, 32'd6};
    vecs[14] = '{32'h100,     1'b1, 32'h100,     1'b0, 1'b1, 32'h1234,    32'h104,      1'b0, 32'h104,     1'b0, 32'h104,     32'd6, 32'd6};
    vecs[15] = '{32'h300,     1'b1, 32'h300,     1'b1, 1'b1, 32'h500,     32'h304,      1'b0, 32'h304,     1'b1, 32'h500,     32'd6, 32'd6};
    vecs[16] = '{32'h300,     1'b0, 32'h0,       1'b0, 1'b0, 32'h0,       32'h0,        1'b1, 32'h500,     1'b0, 32'h0,       32'd7, 32'd7};
    vecs[17] = '{32'h40,      1'b1, 32'h40,      1'b1, 1'b0, 32'h44,      32'h44,       1'b0, 32'h44,      1'b0, 32'h44,      32'd7, 32'd7};
    vecs[18] = '{32'h40,      1'b0, 32'h0,       1'b0, 1'b0, 32'h0,       32'h0,        1'b0, 32'h44,      1'b0, 32'h0,       32'd8, 32'd7};
    vecs[19] = '{32'hFFFFFFFC,1'b1, 32'hFFFFFFFC,1'b0, 1'b0, 32'h0,       32'h0,        1'b0, 32'h0,       1'b0, 32'h0,       32'd8, 32'd7};
    vecs[20] = '{32'h300,     1'b0, 32'h300,     1'b1, 1'b1, 32'h900,     32'h0,        1'b1, 32'h500,     1'b0, 32'h0,       32'd8, 32'd7};
    vecs[21] = '{32'h300,     1'b0, 32'h0,       1'b0, 1'b0, 32'h0,       32'h0,        1'b1, 32'h500,     1'b0, 32'h0,       32'd8, 32'd7};

    rstN = 1'b0;
    drive(vecs[0]);
    repeat (2) @(negedge clk);
    rstN = 1'b1;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i]);
      #1;
      check_row(vecs[i], i);
      @(negedge clk);
    end

    // Reset mid-run: pending taken-branch update at 0x300 with nonzero counters.
    fetchPc = 32'h300; exValid = 1'b1; exPc = 32'h300; exIsBranch = 1'b1;
    exIsBranchTaken = 1'b1; exIrregPc = 32'h700; exPredictedPc = 32'h0;
    #1;
    chk("pre_reset_bc", 100, branchCount, 32'd8);
    #1;
    rstN = 1'b0;
    #1;
    chk("rst_bc", 100, branchCount, 32'd0);
    chk("rst_mc", 100, mispredictCount, 32'd0);
    chk("rst_pt", 100, {31'd0, predictTaken}, 32'd0);
    chk("rst_pp", 100, predictedPc, 32'h304);
    chk("rst_mp", 100, {31'd0, mispredict}, 32'd1);
    chk("rst_rd", 100, redirectPc, 32'h700);
    @(negedge clk);
    rstN = 1'b1;
    exValid = 1'b0;
    #1;
    chk("post_rst_pt", 101, {31'd0, predictTaken}, 32'd0);
    chk("post_rst_pp", 101, predictedPc, 32'h304);
    chk("post_rst_bc", 101, branchCount, 32'd0);
    chk("post_rst_mc", 101, mispredictCount, 32'd0);
    @(negedge clk);
    fetchPc = 32'h200;
    #1;
    chk("post_rst_200", 102, predictedPc, 32'h204);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
